sr_icache: RTL
==============

Name: sr_icache

Overview:
- Direct-mapped, read-only instruction cache between the schoolRISCV core fetch port and instruction memory.
- CPU side: combinational lookup on a held address, returning data plus a ready strobe, the same way the core already consumes imData/im_drdy.
- Memory side: on a miss, refills a whole line with a per-word request/valid handshake.
- Also provides flush and a miss counter for performance measurement.

Parameters:
- LINES, 16: number of cache lines; power of 2, ≥2.
- WORDS, 4: 32-bit words per line; power of 2, ≥2.
- Derived:
  - OFF_W = log2(WORDS), INDEX_W = log2(LINES), TAG_W = 30 − OFF_W − INDEX_W.
  - Byte-address split: [1:0] ignored; [OFF_W+1:2] word offset; next INDEX_W bits index; top TAG_W bits tag.
  - Defaults: offset [3:2], index [7:4], tag [31:8].

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_addr  in  32  fetch byte address; held stable by the core while cpu_drdy=0.
- cpu_rdata  out  32  instruction word; 0 whenever cpu_drdy=0.
- cpu_drdy  out  1  hit indication; cpu_rdata valid this cycle.
- flush  in  1  one-cycle pulse; invalidates all lines.
- mem_req  out  1  refill word request, registered.
- mem_addr  out  32  word-aligned refill address, registered.
- mem_rdata  in  32  refill data.
- mem_rvalid  in  1  mem_rdata valid; beat accepted when mem_req & mem_rvalid.
- miss_cnt  out  32  number of misses since reset.

Behaviour:
- Reset (async, immediate):
  - state=LOOKUP; all valid bits 0; beat counter 0; flush_pend 0.
  - mem_req=0, mem_addr=0, miss_cnt=0, hence cpu_drdy=0 and cpu_rdata=0.
  - Tag and data arrays are not reset.
- Storage: valid[LINES] flops; tag[LINES][TAG_W]; data[LINES*WORDS][32] implemented as flops/LUT-RAM with asynchronous read.
- LOOKUP state:
  - hit = valid[idx] & (tag[idx]==cpu_tag), combinational.
  - cpu_drdy=hit; cpu_rdata = hit ? data[idx][off] : 0. Zero-latency hit, same cycle.
  - On miss with no flush this cycle:
    - latch miss tag and index;
    - next state REFILL;
    - mem_req←1, mem_addr←{tag,idx,OFF_W'b0,2'b00}, beat←0;
    - miss_cnt←miss_cnt+1, wrapping at 2^32.
  - flush in LOOKUP: all valid←0 at the clock edge. A hit in that same cycle is still reported. A miss in that same cycle does not start a refill; the lookup repeats next cycle.
- REFILL state:
  - cpu_drdy=0 throughout.
  - Each cycle with mem_rvalid=1:
    - data[idx][beat]←mem_rdata;
    - beat←beat+1;
    - mem_addr←mem_addr+4.
  - mem_rvalid=0 inserts a wait state; mem_req stays 1 and mem_addr is held.
  - On the last beat (beat==WORDS−1 and mem_rvalid):
    - mem_req←0;
    - tag[idx]←miss tag;
    - valid[idx]←~(flush_pend|flush);
    - all other valid←0 if flush_pend|flush;
    - flush_pend←0;
    - state←LOOKUP.
  - flush during REFILL (not on the last beat) sets flush_pend; the refill runs to completion (no memory transaction is abandoned).
  - Critical word is not forwarded. The earliest hit is the cycle after the last beat.
  - Zero-wait memory: miss detected at cycle N, beats at N+1..N+WORDS, hit at N+WORDS+1.
- mem_rvalid while mem_req=0 is ignored.
- cpu_addr changing while cpu_drdy=0 is a protocol violation. The refill still fills the latched line, and the next LOOKUP uses the current cpu_addr.
- Replacement: a miss overwrites the indexed line unconditionally (direct-mapped eviction).
- Reset asserted mid-refill aborts immediately: mem_req drops asynchronously, and the partially written line stays invalid.

Test Plan:
- Cold miss: reset, cpu_addr=0x00, memory with zero wait returning word i = 0x1000+i.
  - Required: miss_cnt=1; mem_addr 0x00,0x04,0x08,0x0C on consecutive cycles; mem_req low after 4 beats; cpu_drdy=1, cpu_rdata=0x1000 at cycle N+5.
- Line hits: after the cold miss, step cpu_addr 0x04, 0x08, 0x0C.
  - Required: cpu_drdy=1 each cycle; data 0x1001..0x1003; mem_req stays 0; miss_cnt stays 1.
- Conflict eviction: fill 0x000, then fetch 0x100 (same index 0, tag 1), then 0x000 again.
  - Required: 3 refills, miss_cnt=3; the final refill rereads 0x000–0x00C.
- Wait states: memory asserts mem_rvalid every third cycle.
  - Required: mem_addr holds between beats; refill takes 12 cycles; returned data correct.
- Flush: fill lines 0 and 1, pulse flush in LOOKUP, refetch 0x000.
  - Required: miss, miss_cnt increments.
  - Variant: flush mid-refill. Required: refill completes, next lookup of the same address misses again.
- Reset mid-refill: assert rst after 2 beats, release, fetch 0x00.
  - Required: mem_req drops asynchronously; miss_cnt=0 then 1; full 4-beat refill from 0x00.

Source files
------------

// File: rtl/sr_icache.sv
// Direct-mapped read-only instruction cache for the schoolRISCV fetch port.
// Hits return data in the same cycle; misses refill a whole line one word per beat.
module sr_icache #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_addr,
  output logic [31:0] cpu_rdata,
  output logic        cpu_drdy,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic [31:0] miss_cnt
);

  localparam int OFF_W   = $clog2(WORDS);
  localparam int INDEX_W = $clog2(LINES);
  localparam int TAG_W   = 30 - OFF_W - INDEX_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS - 1);

  typedef enum logic {
    LOOKUP,
    REFILL
  } state_t;

  state_t             state;
  logic [LINES-1:0]   valid;
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [31:0]        data_mem [LINES*WORDS];
  logic [OFF_W-1:0]   beat;
  logic [INDEX_W-1:0] miss_idx;
  logic [TAG_W-1:0]   miss_tag;
  logic               flush_pend;

  logic [OFF_W-1:0]   cpu_off;
  logic [INDEX_W-1:0] cpu_idx;
  logic [TAG_W-1:0]   cpu_tag;
  logic [1:0]         unused_byte_sel;
  logic               hit;
  logic               lookup_hit;
  logic               beat_ok;
  logic               last_beat;

  assign cpu_off         = cpu_addr[OFF_W+1:2];
  assign cpu_idx         = cpu_addr[OFF_W+INDEX_W+1:OFF_W+2];
  assign cpu_tag         = cpu_addr[31:32-TAG_W];
  assign unused_byte_sel = cpu_addr[1:0];

  assign hit        = valid[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);
  assign lookup_hit = (state == LOOKUP) && hit;
  assign cpu_drdy   = lookup_hit;
  assign cpu_rdata  = lookup_hit ? data_mem[{cpu_idx, cpu_off}] : 32'h0;

  assign beat_ok   = (state == REFILL) && mem_rvalid;
  assign last_beat = beat_ok && (beat == LAST_BEAT);

  // Control FSM: a flush arriving mid-refill is parked in flush_pend so the
  // memory transaction always completes, then applied as the line is closed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LOOKUP;
      valid      <= '0;
      beat       <= '0;
      flush_pend <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= 32'h0;
      miss_cnt   <= 32'h0;
      miss_idx   <= '0;
      miss_tag   <= '0;
    end else begin
      case (state)
        LOOKUP: begin
          if (flush) begin
            valid <= '0;
          end else if (!hit) begin
            miss_idx <= cpu_idx;
            miss_tag <= cpu_tag;
            state    <= REFILL;
            mem_req  <= 1'b1;
            mem_addr <= {cpu_tag, cpu_idx, {OFF_W{1'b0}}, 2'b00};
            beat     <= '0;
            miss_cnt <= miss_cnt + 32'd1;
          end
        end
        REFILL: begin
          if (mem_rvalid) begin
            beat     <= beat + OFF_W'(1);
            mem_addr <= mem_addr + 32'd4;
          end
          if (last_beat) begin
            mem_req    <= 1'b0;
            state      <= LOOKUP;
            flush_pend <= 1'b0;
            if (flush_pend || flush) begin
              valid <= '0;
            end else begin
              valid[miss_idx] <= 1'b1;
            end
          end else if (flush) begin
            flush_pend <= 1'b1;
          end
        end
        default: state <= LOOKUP;
      endcase
    end
  end

  // Tag and data storage carry no reset; valid bits alone guard them.
  always_ff @(posedge clk) begin
    if (beat_ok) begin
      data_mem[{miss_idx, beat}] <= mem_rdata;
    end
    if (last_beat) begin
      tag_mem[miss_idx] <= miss_tag;
    end
  end

endmodule
